// File: rtl/pc_redirect_unit_if.sv
// Fetch-side bundle between the branch/jump resolvers and the PC redirect unit.
interface pc_redirect_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             jump;
    logic [WIDTH-1:0] jump_target;
    logic             trap_ack;
    logic [WIDTH-1:0] pc;
    logic             flush;
    logic             misaligned;
    logic [WIDTH-1:0] trap_addr;
    logic [31:0]      redirect_cnt;

    // Requester side: drives redirect requests and back-pressure, observes PC.
    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, trap_ack,
        input  pc, flush, misaligned, trap_addr, redirect_cnt
    );

    // PC unit side.
    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, trap_ack,
        output pc, flush, misaligned, trap_addr, redirect_cnt
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with redirect handling: taken branches/jumps load the
// target and open a fixed-length flush window, misaligned targets park the
// unit in TRAP until acknowledged, and accepted redirects are counted.
module pc_redirect_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VEC     = 32'h0000_0100,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_redirect_unit_if.slave    bus
);
    typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pc_q, pc_n;
    logic             flush_q, flush_n;
    logic             mis_q, mis_n;
    logic [WIDTH-1:0] taddr_q, taddr_n;
    logic [31:0]      cnt_q, cnt_n;
    logic [2:0]       fcnt_q, fcnt_n;

    logic             req;
    logic [WIDTH-1:0] tgt;

    // Jump wins over a simultaneous branch.
    assign req = bus.branch_taken | bus.jump;
    assign tgt = bus.jump ? bus.jump_target : bus.branch_target;

    // Next-state and next-register values; everything holds by default.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        mis_n   = mis_q;
        taddr_n = taddr_q;
        cnt_n   = cnt_q;
        fcnt_n  = fcnt_q;
        case (state)
            RUN: begin
                if (req) begin
                    if (tgt[1:0] == 2'b00) begin
                        // A redirect is taken even when fetch is stalled.
                        pc_n    = tgt;
                        cnt_n   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                        fcnt_n  = 3'(FLUSH_CYCLES);
                        state_n = FLUSH;
                    end else begin
                        mis_n   = 1'b1;
                        taddr_n = tgt;
                        state_n = TRAP;
                    end
                end else if (!bus.stall) begin
                    pc_n = pc_q + WIDTH'(4);
                end
            end
            FLUSH: begin
                // Requests here come from squashed instructions and are dropped.
                if (!bus.stall) pc_n = pc_q + WIDTH'(4);
                fcnt_n = fcnt_q - 3'd1;
                if (fcnt_q <= 3'd1) state_n = RUN;
            end
            TRAP: begin
                if (bus.trap_ack) begin
                    pc_n    = TRAP_VEC;
                    mis_n   = 1'b0;
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
        // flush is registered so it is high exactly while the FSM sits in FLUSH.
        flush_n = (state_n == FLUSH);
    end

    // State and output registers; reset dominates every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
            taddr_q <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            flush_q <= flush_n;
            mis_q   <= mis_n;
            taddr_q <= taddr_n;
            cnt_q   <= cnt_n;
            fcnt_q  <= fcnt_n;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.flush        = flush_q;
    assign bus.misaligned   = mis_q;
    assign bus.trap_addr    = taddr_q;
    assign bus.redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: each stimulus cycle queues the
// hand-computed post-edge outputs; a monitor pops and checks after each edge.
module tb_pc_redirect_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_redirect_unit_if #(.WIDTH(32)) bus();

    pc_redirect_unit #(
        .WIDTH(32), .RESET_PC(32'h0), .TRAP_VEC(32'h100), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic [31:0] taddr;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;
    int   vec_id = 0;

    // Drive one cycle of inputs and queue what must appear after the next edge.
    task automatic step(input logic r, input logic s,
                        input logic bt, input logic [31:0] btgt,
                        input logic j, input logic [31:0] jtgt, input logic ack,
                        input logic [31:0] epc, input logic ef, input logic em,
                        input logic [31:0] eta, input logic [31:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst               = r;
        bus.stall         = s;
        bus.branch_taken  = bt;
        bus.branch_target = btgt;
        bus.jump          = j;
        bus.jump_target   = jtgt;
        bus.trap_ack      = ack;
        vec_id++;
        e.id = vec_id; e.pc = epc; e.flush = ef; e.mis = em; e.taddr = eta; e.cnt = ecnt;
        q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] epc, input logic ef, input logic em,
                        input logic [31:0] eta, input logic [31:0] ecnt);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, epc, ef, em, eta, ecnt);
    endtask

    // Monitor: every edge with pending expectations yields one check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (bus.pc !== e.pc || bus.flush !== e.flush || bus.misaligned !== e.mis ||
                    bus.trap_addr !== e.taddr || bus.redirect_cnt !== e.cnt) begin
                    failed++;
                    $display("FAIL vec%0d: got pc=%h flush=%b mis=%b taddr=%h cnt=%0d, want pc=%h flush=%b mis=%b taddr=%h cnt=%0d",
                             e.id, bus.pc, bus.flush, bus.misaligned, bus.trap_addr, bus.redirect_cnt,
                             e.pc, e.flush, e.mis, e.taddr, e.cnt);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
        bus.jump = 0; bus.jump_target = 0; bus.trap_ack = 0;

        // 1: reset, free run
        step(1, 0, 0, 0, 0, 0, 0,  32'h0, 0, 0, 32'h0, 0);
        idle(32'h4, 0, 0, 0, 0);
        idle(32'h8, 0, 0, 0, 0);
        // 2: taken branch at pc=8, then a branch pulse inside the flush window
        step(0, 0, 1, 32'h40, 0, 0, 0,  32'h40, 1, 0, 0, 1);
        step(0, 0, 1, 32'h80, 0, 0, 0,  32'h44, 1, 0, 0, 1);
        idle(32'h48, 0, 0, 0, 1);
        idle(32'h4C, 0, 0, 0, 1);
        // 3: jump beats branch and stall; misaligned jump during flush ignored
        step(0, 1, 1, 32'h300, 1, 32'h200, 0,  32'h200, 1, 0, 0, 2);
        step(0, 1, 0, 32'h0,   1, 32'h101, 0,  32'h200, 1, 0, 0, 2);
        idle(32'h204, 0, 0, 0, 2);
        // 4: misaligned trap, frozen for 5 cycles, then acknowledged
        step(0, 0, 1, 32'h102, 0, 0, 0,  32'h204, 0, 1, 32'h102, 2);
        step(0, 0, 1, 32'h40,  0, 0, 0,  32'h204, 0, 1, 32'h102, 2);
        step(0, 1, 0, 32'h0,   0, 0, 0,  32'h204, 0, 1, 32'h102, 2);
        step(0, 0, 0, 32'h0,   1, 32'h80, 0, 32'h204, 0, 1, 32'h102, 2);
        idle(32'h204, 0, 1, 32'h102, 2);
        idle(32'h204, 0, 1, 32'h102, 2);
        step(0, 0, 0, 32'h0, 0, 0, 1,  32'h100, 0, 0, 32'h102, 2);
        idle(32'h104, 0, 0, 32'h102, 2);
        step(0, 0, 0, 32'h0, 0, 0, 1,  32'h108, 0, 0, 32'h102, 2);
        // 5: wrap at the top of the address space, then stall
        step(0, 0, 0, 32'h0, 1, 32'hFFFF_FFF0, 0,  32'hFFFF_FFF0, 1, 0, 32'h102, 3);
        idle(32'hFFFF_FFF4, 1, 0, 32'h102, 3);
        idle(32'hFFFF_FFF8, 0, 0, 32'h102, 3);
        idle(32'hFFFF_FFFC, 0, 0, 32'h102, 3);
        idle(32'h0, 0, 0, 32'h102, 3);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 32'h0, 0, 0, 0,  32'h0, 0, 0, 32'h102, 3);
        idle(32'h4, 0, 0, 32'h102, 3);
        // 6: reset in the first flush cycle, then back in RUN
        step(0, 0, 1, 32'h80, 0, 0, 0,  32'h80, 1, 0, 32'h102, 4);
        step(1, 0, 1, 32'h40, 0, 0, 0,  32'h0, 0, 0, 32'h0, 0);
        idle(32'h4, 0, 0, 0, 0);
        // reset while parked in TRAP
        step(0, 0, 1, 32'h3, 0, 0, 0,  32'h4, 0, 1, 32'h3, 0);
        step(1, 0, 0, 32'h0, 0, 0, 1,  32'h0, 0, 0, 32'h0, 0);
        idle(32'h4, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Program-counter register and redirect controller, directly downstream of branch_unit.
- Consumes branch_taken and the resolved target, and drives the fetch PC.
- Generates a multi-cycle pipeline flush after every taken redirect.
- Traps misaligned targets and counts taken redirects for performance monitoring.

Parameters:
WIDTH, 32, datapath and PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded when a misaligned-target trap is acknowledged
FLUSH_CYCLES, 2, number of cycles flush stays high after a redirect (legal range 1..7)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold PC (fetch back-pressure)
branch_taken  input  1  from branch_unit; conditional branch resolved taken
branch_target  input  WIDTH  target address of the taken branch
jump  input  1  unconditional jump (JAL/JALR) request
jump_target  input  WIDTH  jump target address
trap_ack  input  1  trap handler acknowledges the misaligned trap
pc  output  WIDTH  current fetch PC (registered)
flush  output  1  squash younger in-flight instructions
misaligned  output  1  misaligned-target trap pending
trap_addr  output  WIDTH  offending target address
redirect_cnt  output  32  number of accepted redirects, saturating

Behaviour:
- Reset: clk and rst form one clock domain; reset is synchronous and active-high. All outputs are registered. In the cycle after rst is sampled high:
  - pc=RESET_PC, flush=0, misaligned=0, trap_addr=0, redirect_cnt=0, state=RUN, flush counter=0.
  - rst overrides every other input in every state, including mid-FLUSH and mid-TRAP.
- States: RUN, FLUSH, TRAP.
- Redirect request: req = branch_taken | jump. tgt = jump ? jump_target : branch_target, so jump has priority when both are high.
- RUN, req=1, tgt[1:0]==0:
  - pc<=tgt, redirect_cnt<=redirect_cnt+1 (holds at 32'hFFFF_FFFF), counter<=FLUSH_CYCLES, go FLUSH.
  - A redirect overrides stall.
- RUN, req=1, tgt[1:0]!=0:
  - go TRAP, misaligned<=1, trap_addr<=tgt.
  - pc holds; redirect_cnt unchanged.
- RUN, req=0: stall=1 holds pc; otherwise pc<=pc+4, wrapping modulo 2^WIDTH (32'hFFFF_FFFC -> 0).
- FLUSH:
  - flush=1 in every FLUSH cycle, i.e. the FLUSH_CYCLES cycles immediately after the redirect edge.
  - branch_taken and jump are ignored, because they come from squashed instructions.
  - pc advances by +4 unless stall=1.
  - The counter decrements every cycle regardless of stall. When the counter is 1, the next state is RUN and flush drops in the same edge.
- TRAP:
  - pc holds, flush=0, misaligned=1, trap_addr stable; req and stall are ignored.
  - trap_ack=1: pc<=TRAP_VEC, misaligned<=0, trap_addr holds its value, go RUN.
  - trap_ack is ignored in RUN and FLUSH.
- Latency:
  - A redirect sampled at edge N gives pc=tgt and flush=1 after edge N.
  - flush returns to 0 after edge N+FLUSH_CYCLES.
- branch_unit already gates branch_taken with is_branch, so this block applies no extra qualification.

Test Plan:
1. Reset then free run: rst=1 for 1 cycle, stall=0 -> pc=0,4,8,12 on consecutive cycles; flush=0, redirect_cnt=0.
2. Taken branch: branch_taken=1, branch_target=32'h0000_0040 for one cycle at pc=8 ->
   - next cycle pc=0x40, flush=1 for exactly 2 cycles, pc then 0x44, 0x48;
   - redirect_cnt=1; a branch_taken pulse during flush changes nothing.
3. Priority: jump=1, jump_target=0x200, branch_taken=1, branch_target=0x300, stall=1 -> pc=0x200, flush=1; stall does not block the redirect.
4. Misaligned trap: branch_taken=1, branch_target=0x102 ->
   - misaligned=1, trap_addr=0x102, pc frozen across 5 cycles of stimulus;
   - trap_ack=1 -> pc=0x100, misaligned=0, then 0x104.
5. Wrap and stall: reach pc=32'hFFFF_FFFC, stall=0 -> pc=0 next cycle; stall=1 for 3 cycles -> pc constant.
6. Reset mid-FLUSH: assert rst in the first flush cycle -> next cycle pc=RESET_PC, flush=0, redirect_cnt=0, state RUN.
